// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types, constants and opcode helpers for the milano core
package milano_pkg;

   typedef enum logic [6:0] {
      OPCODE_LOAD     = 7'h03,
      OPCODE_MISC_MEM = 7'h0F,
      OPCODE_OP_IMM   = 7'h13,
      OPCODE_AUIPC    = 7'h17,
      OPCODE_STORE    = 7'h23,
      OPCODE_OP       = 7'h33,
      OPCODE_LUI      = 7'h37,
      OPCODE_BRANCH   = 7'h63,
      OPCODE_JALR     = 7'h67,
      OPCODE_JAL      = 7'h6F,
      OPCODE_SYSTEM   = 7'h73
   } opcode_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } fetch_entry_t;

   typedef enum logic {
      FETCH_IDLE,
      FETCH_REQ
   } fetch_state_e;

   localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;

   function automatic logic is_legal_opcode(input opcode_e op);
      case (op)
         OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
         OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
         OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: is_legal_opcode = 1'b1;
         default:                                is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/milano_if_stage_if.sv
// rtl/milano_if_stage_if.sv - instruction bus and fetch-to-decode handshake bundle
interface milano_if_stage_if;
   import milano_pkg::*;

   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;

   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [6:0]  id_opcode_o;
   logic        id_illegal_o;
   logic        id_err_o;

   modport master (
      output instr_req_o, instr_addr_o,
      input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
      output id_valid_o, id_instr_o, id_pc_o, id_opcode_o, id_illegal_o, id_err_o,
      input  id_ready_i
   );

   modport slave (
      input  instr_req_o, instr_addr_o,
      output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
      input  id_valid_o, id_instr_o, id_pc_o, id_opcode_o, id_illegal_o, id_err_o,
      output id_ready_i
   );

endinterface

// File: rtl/milano_fetch_fifo.sv
// rtl/milano_fetch_fifo.sv - registered fetch buffer with flush; head is visible the cycle after push
module milano_fetch_fifo
   import milano_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         valid,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign valid = (count != '0);

endmodule

// File: rtl/milano_if_stage.sv
// rtl/milano_if_stage.sv - instruction fetch: bus requests, pc tracking, redirect discard, ID handoff
module milano_if_stage
   import milano_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR       = BOOT_ADDR_DEFAULT,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_enable_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   milano_if_stage_if.master bus
);

   localparam int CW  = $clog2(2 * FIFO_DEPTH + 2);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int QW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   fetch_state_e   state_q, state_d;
   logic [31:0]    fetch_addr_q, fetch_addr_d;
   logic           redir_pend_q, redir_pend_d;
   logic [31:0]    redir_addr_q, redir_addr_d;
   logic [CW-1:0]  outstanding_q, outstanding_d;
   logic [CW-1:0]  discard_q, discard_d;
   logic [CW-1:0]  fifo_count_d;
   logic [31:0]    pc_q [MAX_OUTSTANDING];
   logic [QW-1:0]  pc_wr_q, pc_rd_q;

   logic           granted, hold, resp_keep, pop;
   logic [31:0]    branch_tgt;
   fetch_entry_t   push_data, head;
   logic           fifo_valid;
   logic [FCW-1:0] fifo_count;
   opcode_e        head_op;

   function automatic logic [QW-1:0] next_q(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
   endfunction

   assign bus.instr_req_o  = (state_q == FETCH_REQ);
   assign bus.instr_addr_o = fetch_addr_q;

   assign granted    = bus.instr_req_o && bus.instr_gnt_i;
   assign hold       = bus.instr_req_o && !bus.instr_gnt_i;
   assign branch_tgt = branch_addr_i & ~32'h3;
   assign resp_keep  = bus.instr_rvalid_i && !branch_i && (discard_q == '0);
   assign pop        = bus.id_valid_o && bus.id_ready_i;

   // Space is reserved at request time: in-flight responses plus buffered entries never exceed FIFO_DEPTH
   always_comb begin
      outstanding_d = outstanding_q + CW'(granted) - CW'(bus.instr_rvalid_i);
      fifo_count_d  = branch_i ? '0 : CW'(fifo_count) + CW'(resp_keep) - CW'(pop);
      state_d       = FETCH_IDLE;
      if (hold)
         state_d = FETCH_REQ;
      else if (fetch_enable_i && ((outstanding_d + fifo_count_d) < CW'(FIFO_DEPTH))
               && (outstanding_d < CW'(MAX_OUTSTANDING)))
         state_d = FETCH_REQ;
   end

   // A redirect during an ungranted request is parked until the bus takes the old address
   always_comb begin
      fetch_addr_d = fetch_addr_q;
      redir_pend_d = redir_pend_q;
      redir_addr_d = redir_addr_q;
      discard_d    = discard_q;
      if (branch_i) begin
         discard_d = outstanding_q - CW'(bus.instr_rvalid_i) + CW'(bus.instr_req_o);
         if (hold) begin
            redir_pend_d = 1'b1;
            redir_addr_d = branch_tgt;
         end else begin
            fetch_addr_d = branch_tgt;
            redir_pend_d = 1'b0;
         end
      end else begin
         if (bus.instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
         if (granted) begin
            fetch_addr_d = redir_pend_q ? redir_addr_q : fetch_addr_q + 32'd4;
            redir_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= FETCH_IDLE;
         fetch_addr_q  <= BOOT_ADDR;
         redir_pend_q  <= 1'b0;
         redir_addr_q  <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         pc_wr_q       <= '0;
         pc_rd_q       <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) pc_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         redir_pend_q  <= redir_pend_d;
         redir_addr_q  <= redir_addr_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         if (granted) begin
            pc_q[pc_wr_q] <= fetch_addr_q;
            pc_wr_q       <= next_q(pc_wr_q);
         end
         if (bus.instr_rvalid_i) pc_rd_q <= next_q(pc_rd_q);
      end
   end

   assign push_data = '{instr: bus.instr_rdata_i, pc: pc_q[pc_rd_q], err: bus.instr_err_i};

   milano_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (FCW)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush     (branch_i),
      .push      (resp_keep),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign head_op          = opcode_e'(head.instr[6:0]);
   assign bus.id_valid_o   = fifo_valid && !branch_i;
   assign bus.id_instr_o   = head.instr;
   assign bus.id_pc_o      = head.pc;
   assign bus.id_opcode_o  = bus.id_valid_o ? head.instr[6:0] : 7'h00;
   assign bus.id_illegal_o = bus.id_valid_o
                             && ((head.instr[1:0] != 2'b11) || !is_legal_opcode(head_op));
   assign bus.id_err_o     = bus.id_valid_o && head.err;

endmodule

// File: tb/tb_milano_if_stage.sv
// tb/tb_milano_if_stage.sv - directed bench for milano_if_stage with a simple in-order bus model
module tb_milano_if_stage;
   import milano_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_enable;
   logic        branch;
   logic [31:0] branch_addr;
   logic        rsp_en;

   milano_if_stage_if bus ();

   milano_if_stage #(
      .BOOT_ADDR       (32'h0000_0080),
      .FIFO_DEPTH      (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .fetch_enable_i (fetch_enable),
      .branch_i       (branch),
      .branch_addr_i  (branch_addr),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [6:0]  op;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  op;
      logic        ill;
      logic        err;
   } cap_t;

   vec_t        vec [8];
   cap_t        cap_q [$];
   logic [31:0] pend_q [$];
   logic [31:0] gnt_log [$];
   logic [31:0] rsp_addr;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          first_rv = -1;
   int          first_v = -1;
   int          unstable;
   int          n0;

   function automatic logic in_tbl(input logic [31:0] a);
      return (a >= 32'h80) && (a < 32'hA0);
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (in_tbl(a)) return vec[int'((a - 32'h80) >> 2)].rdata;
      return {a[23:0], 8'h13};
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      if (in_tbl(a)) return vec[int'((a - 32'h80) >> 2)].err;
      return 1'b0;
   endfunction

   always @(posedge clk) cyc++;

   // Memory side: answers each granted address one cycle later, in order
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         pend_q.delete();
         bus.instr_rvalid_i = 1'b0;
         bus.instr_rdata_i  = '0;
         bus.instr_err_i    = 1'b0;
      end else if (rsp_en && pend_q.size() > 0) begin
         rsp_addr           = pend_q.pop_front();
         bus.instr_rvalid_i = 1'b1;
         bus.instr_rdata_i  = mem_word(rsp_addr);
         bus.instr_err_i    = mem_err(rsp_addr);
      end else begin
         bus.instr_rvalid_i = 1'b0;
         bus.instr_rdata_i  = '0;
         bus.instr_err_i    = 1'b0;
      end
   end

   always @(negedge clk) begin
      cap_t c;
      if (rst_n) begin
         if (bus.instr_req_o && bus.instr_gnt_i) begin
            pend_q.push_back(bus.instr_addr_o);
            gnt_log.push_back(bus.instr_addr_o);
         end
         if (bus.instr_rvalid_i && first_rv < 0) first_rv = cyc;
         if (bus.id_valid_o && first_v < 0) first_v = cyc;
         if (bus.id_valid_o && bus.id_ready_i) begin
            c.pc    = bus.id_pc_o;
            c.instr = bus.id_instr_o;
            c.op    = bus.id_opcode_o;
            c.ill   = bus.id_illegal_o;
            c.err   = bus.id_err_o;
            cap_q.push_back(c);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      fetch_enable     = 1'b0;
      branch           = 1'b0;
      branch_addr      = '0;
      rsp_en           = 1'b0;
      bus.instr_gnt_i  = 1'b0;
      bus.id_ready_i   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      cap_q.delete();
      gnt_log.delete();
      first_rv = -1;
      first_v  = -1;
      rst_n    = 1'b1;
   endtask

   task automatic wait_cap(input int n, input int budget, input string name);
      int k = 0;
      while (cap_q.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(name, 32'(cap_q.size() >= n), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec[0] = '{32'h0000_0000, 1'b0, 7'h00, 1'b1};
      vec[1] = '{32'h0000_007F, 1'b0, 7'h7F, 1'b1};
      vec[2] = '{32'h00A0_0093, 1'b1, 7'h13, 1'b0};
      vec[3] = '{32'h0000_0013, 1'b0, 7'h13, 1'b0};
      vec[4] = '{32'h0000_0062, 1'b0, 7'h62, 1'b1};
      vec[5] = '{32'h0000_006F, 1'b0, 7'h6F, 1'b0};
      vec[6] = '{32'h0000_0033, 1'b0, 7'h33, 1'b0};
      vec[7] = '{32'h0000_0077, 1'b0, 7'h77, 1'b1};

      do_reset();
      chk("rst_req",     32'(bus.instr_req_o),  32'd0);
      chk("rst_addr",    bus.instr_addr_o,      32'h80);
      chk("rst_valid",   32'(bus.id_valid_o),   32'd0);
      chk("rst_instr",   bus.id_instr_o,        32'd0);
      chk("rst_pc",      bus.id_pc_o,           32'd0);
      chk("rst_opcode",  32'(bus.id_opcode_o),  32'd0);
      chk("rst_illegal", 32'(bus.id_illegal_o), 32'd0);
      chk("rst_err",     32'(bus.id_err_o),     32'd0);

      // Streaming fetch through the table region
      fetch_enable    = 1'b1;
      bus.instr_gnt_i = 1'b1;
      bus.id_ready_i  = 1'b1;
      rsp_en          = 1'b1;
      wait_cap(8, 200, "t1_timeout");
      if (gnt_log.size() > 0) chk("t1_first_gnt", gnt_log[0], 32'h80);
      chk("t1_latency", 32'(first_v - first_rv), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i < cap_q.size()) begin
            chk($sformatf("t1_pc%0d", i),      cap_q[i].pc,        32'h80 + 32'(4 * i));
            chk($sformatf("t1_instr%0d", i),   cap_q[i].instr,     vec[i].rdata);
            chk($sformatf("t1_opcode%0d", i),  32'(cap_q[i].op),   32'(vec[i].op));
            chk($sformatf("t1_illegal%0d", i), 32'(cap_q[i].ill),  32'(vec[i].ill));
            chk($sformatf("t1_err%0d", i),     32'(cap_q[i].err),  32'(vec[i].err));
         end
      end

      // Asynchronous reset in the middle of traffic
      rst_n = 1'b0;
      #1;
      chk("arst_req",   32'(bus.instr_req_o), 32'd0);
      chk("arst_addr",  bus.instr_addr_o,     32'h80);
      chk("arst_valid", 32'(bus.id_valid_o),  32'd0);
      chk("arst_pc",    bus.id_pc_o,          32'd0);

      // Decoder stalls: fetching stops once the buffer is committed
      do_reset();
      fetch_enable    = 1'b1;
      bus.instr_gnt_i = 1'b1;
      rsp_en          = 1'b1;
      repeat (4) step();
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h80 || bus.id_instr_o !== mem_word(32'h80))
            unstable++;
         step();
      end
      chk("t2_unstable",  32'(unstable),       32'd0);
      chk("t2_grants",    32'(gnt_log.size()), 32'd2);
      chk("t2_req_idle",  32'(bus.instr_req_o), 32'd0);
      chk("t2_pc_held",   bus.id_pc_o,         32'h80);
      bus.id_ready_i = 1'b1;
      wait_cap(4, 100, "t2_drain_timeout");
      for (int i = 0; i < 4; i++) begin
         if (i < cap_q.size()) begin
            chk($sformatf("t2_pc%0d", i),    cap_q[i].pc,    32'h80 + 32'(4 * i));
            chk($sformatf("t2_instr%0d", i), cap_q[i].instr, mem_word(32'h80 + 32'(4 * i)));
         end
      end

      // Branch while an entry is presented: nothing pops, buffer flushed
      bus.id_ready_i = 1'b0;
      repeat (8) step();
      chk("t2b_valid_before", 32'(bus.id_valid_o), 32'd1);
      n0             = cap_q.size();
      branch         = 1'b1;
      branch_addr    = 32'h300;
      bus.id_ready_i = 1'b1;
      #1;
      chk("t2b_valid_in_branch", 32'(bus.id_valid_o), 32'd0);
      step();
      branch = 1'b0;
      chk("t2b_no_pop", 32'(cap_q.size()), 32'(n0));
      wait_cap(n0 + 1, 60, "t2b_timeout");
      if (cap_q.size() > n0) chk("t2b_target_pc", cap_q[n0].pc, 32'h300);

      // Branch with two responses outstanding
      do_reset();
      fetch_enable    = 1'b1;
      bus.instr_gnt_i = 1'b1;
      bus.id_ready_i  = 1'b1;
      for (int k = 0; k < 20 && gnt_log.size() < 2; k++) step();
      chk("t3_two_outstanding", 32'(gnt_log.size()), 32'd2);
      step();
      chk("t3_req_stopped", 32'(bus.instr_req_o), 32'd0);
      branch      = 1'b1;
      branch_addr = 32'h203;
      step();
      branch = 1'b0;
      rsp_en = 1'b1;
      wait_cap(2, 60, "t3_timeout");
      if (cap_q.size() >= 2) begin
         chk("t3_first_pc",    cap_q[0].pc,    32'h200);
         chk("t3_first_instr", cap_q[0].instr, mem_word(32'h200));
         chk("t3_second_pc",   cap_q[1].pc,    32'h204);
      end
      if (gnt_log.size() >= 3) chk("t3_next_addr", gnt_log[2], 32'h200);

      // Branch while a request waits for grant
      do_reset();
      fetch_enable   = 1'b1;
      bus.id_ready_i = 1'b1;
      rsp_en         = 1'b1;
      for (int k = 0; k < 10 && bus.instr_req_o !== 1'b1; k++) step();
      chk("t4_req",  32'(bus.instr_req_o), 32'd1);
      chk("t4_addr", bus.instr_addr_o,     32'h80);
      branch      = 1'b1;
      branch_addr = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step();
         branch = 1'b0;
         if (i == 2) bus.instr_gnt_i = 1'b1;
         chk($sformatf("t4_hold_req%0d", i),  32'(bus.instr_req_o), 32'd1);
         chk($sformatf("t4_hold_addr%0d", i), bus.instr_addr_o,     32'h80);
      end
      wait_cap(1, 60, "t4_timeout");
      if (cap_q.size() >= 1) chk("t4_first_pc", cap_q[0].pc, 32'h200);
      if (gnt_log.size() >= 2) begin
         chk("t4_gnt0", gnt_log[0], 32'h80);
         chk("t4_gnt1", gnt_log[1], 32'h200);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
